// File: rtl/mat2axis_video_tx.sv
// Streams one rows x cols frame from a first-word-fall-through pixel FIFO onto AXI4-Stream video.
// Define MAT2AXIS_STALL_MON_EN to add the stall_block / stall_cnt back-pressure monitor.
module mat2axis_video_tx #(
    parameter int DATA_W = 8,
    parameter int DIM_W  = 11
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ap_start,
    input  logic [DIM_W-1:0]  rows,
    input  logic [DIM_W-1:0]  cols,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_empty,
    output logic              in_read,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tuser,
    output logic              m_axis_tlast,
    output logic              ap_idle,
    output logic              ap_done
`ifdef MAT2AXIS_STALL_MON_EN
   ,output logic              stall_block,
    output logic [15:0]       stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [DIM_W-1:0] rows_q;
    logic [DIM_W-1:0] cols_q;
    logic [DIM_W-1:0] row_cnt;
    logic [DIM_W-1:0] col_cnt;
    logic             pixels_remaining;
    logic             col_wrap;
    logic             out_free;
    logic             handshake;

    // row_cnt reaching rows_q after the last column wrap means every pixel has been popped
    assign pixels_remaining = (rows_q != '0) && (cols_q != '0) && (row_cnt != rows_q);
    assign col_wrap         = (col_cnt == cols_q - DIM_W'(1));
    assign out_free         = ~m_axis_tvalid | m_axis_tready;
    assign handshake        = m_axis_tvalid & m_axis_tready;
    assign in_read          = ~reset & (state == RUN) & ~in_empty & pixels_remaining & out_free;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            ap_idle <= 1'b1;
            ap_done <= 1'b0;
            rows_q  <= '0;
            cols_q  <= '0;
        end else begin
            ap_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ap_start) begin
                        state   <= RUN;
                        ap_idle <= 1'b0;
                        rows_q  <= rows;
                        cols_q  <= cols;
                    end
                end
                RUN: begin
                    // Leave once nothing is left to pop and the output register has drained
                    if (!pixels_remaining && out_free) begin
                        state   <= DONE;
                        ap_done <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    ap_idle <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    ap_idle <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            row_cnt       <= '0;
            col_cnt       <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            if (state == IDLE && ap_start) begin
                row_cnt <= '0;
                col_cnt <= '0;
            end else if (in_read) begin
                if (col_wrap) begin
                    col_cnt <= '0;
                    row_cnt <= row_cnt + DIM_W'(1);
                end else begin
                    col_cnt <= col_cnt + DIM_W'(1);
                end
            end

            if (in_read) begin
                m_axis_tdata  <= in_data;
                m_axis_tuser  <= (row_cnt == '0) && (col_cnt == '0);
                m_axis_tlast  <= col_wrap;
                m_axis_tvalid <= 1'b1;
            end else if (handshake) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tuser  <= 1'b0;
                m_axis_tlast  <= 1'b0;
            end
        end
    end

`ifdef MAT2AXIS_STALL_MON_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_block <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            stall_block <= m_axis_tvalid & ~m_axis_tready;
            if (state == IDLE && ap_start) begin
                stall_cnt <= '0;
            end else if (m_axis_tvalid && !m_axis_tready && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mat2axis_video_tx.sv
// Randomized self-checking bench for mat2axis_video_tx: a beat-level reference model compared every cycle,
// plus directed frames with hand-computed expectations.
module tb_mat2axis_video_tx;

    localparam int DATA_W  = 8;
    localparam int DIM_W   = 11;
    localparam int MASK    = 8191;
    localparam int TIMEOUT = 5000;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              ap_start = 1'b0;
    logic [DIM_W-1:0]  rows = '0;
    logic [DIM_W-1:0]  cols = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_empty = 1'b1;
    logic              in_read;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready = 1'b1;
    logic              m_axis_tuser;
    logic              m_axis_tlast;
    logic              ap_idle;
    logic              ap_done;
`ifdef MAT2AXIS_STALL_MON_EN
    logic              stall_block;
    logic [15:0]       stall_cnt;
`endif

    mat2axis_video_tx #(.DATA_W(DATA_W), .DIM_W(DIM_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .ap_start     (ap_start),
        .rows         (rows),
        .cols         (cols),
        .in_data      (in_data),
        .in_empty     (in_empty),
        .in_read      (in_read),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tlast (m_axis_tlast),
        .ap_idle      (ap_idle),
        .ap_done      (ap_done)
`ifdef MAT2AXIS_STALL_MON_EN
       ,.stall_block  (stall_block),
        .stall_cnt    (stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    // FIFO contents: an endless pixel stream read in order at rd_idx
    logic [DATA_W-1:0] pix [0:MASK];
    int rd_idx = 0;

    // Reference model: phase 0 idle, 1 streaming, 2 done-pulse cycle
    int                m_phase = 0;
    int                m_total = 0;
    int                m_pops = 0;
    int                m_acc = 0;
    int                m_idx = 0;
    int                m_cols = 0;
    logic              m_valid = 1'b0;
    logic [DATA_W-1:0] m_data = '0;
    logic              m_stall_prev = 1'b0;
    logic              exp_rd;
    logic              m_hs;

    int cyc = 0;
    int hs_cnt, tuser_cnt, tlast_cnt, rd_cnt, done_cnt, start_cnt;
    int first_cyc, last_cyc, done_cyc, first_done_cyc, start_cyc;
    logic [DATA_W-1:0] beat_log [0:15];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clearLogs();
        hs_cnt = 0; tuser_cnt = 0; tlast_cnt = 0; rd_cnt = 0; done_cnt = 0; start_cnt = 0;
        first_cyc = -1; last_cyc = -1; done_cyc = -1; first_done_cyc = -1; start_cyc = -1;
    endtask

    // Compare process and model update: outputs sampled mid-cycle, model advanced for the coming edge
    always @(negedge clock) begin
        cyc++;
        exp_rd = !reset && m_phase == 1 && !in_empty && m_pops < m_total && (!m_valid || m_axis_tready);
        checkOutput("ap_idle", ap_idle, m_phase == 0);
        checkOutput("ap_done", ap_done, m_phase == 2);
        checkOutput("in_read", in_read, exp_rd);
        checkOutput("tvalid", m_axis_tvalid, m_valid);
        if (m_valid) begin
            checkOutput("tdata", m_axis_tdata, m_data);
            checkOutput("tuser", m_axis_tuser, m_idx == 0);
            checkOutput("tlast", m_axis_tlast, (m_idx % m_cols) == m_cols - 1);
        end
`ifdef MAT2AXIS_STALL_MON_EN
        checkOutput("stall_block", stall_block, m_stall_prev);
        m_stall_prev = !reset && m_valid && !m_axis_tready;
`endif

        if (m_axis_tvalid && m_axis_tready) begin
            if (hs_cnt < 16) beat_log[hs_cnt] = m_axis_tdata;
            if (hs_cnt == 0) first_cyc = cyc;
            last_cyc = cyc;
            hs_cnt++;
            tuser_cnt += int'(m_axis_tuser);
            tlast_cnt += int'(m_axis_tlast);
        end
        rd_cnt += int'(in_read);
        if (ap_done) begin
            if (done_cnt == 0) first_done_cyc = cyc;
            done_cnt++;
            done_cyc = cyc;
        end

        if (reset) begin
            m_phase = 0;
            m_valid = 1'b0;
            m_pops  = 0;
            m_acc   = 0;
        end else begin
            m_hs = m_valid && m_axis_tready;
            case (m_phase)
                0: if (ap_start) begin
                    m_phase   = 1;
                    m_total   = int'(rows) * int'(cols);
                    m_cols    = int'(cols);
                    m_pops    = 0;
                    m_acc     = 0;
                    start_cyc = cyc;
                    start_cnt++;
                end
                1: begin
                    if (m_hs) m_acc++;
                    if (exp_rd) begin
                        m_data  = pix[rd_idx & MASK];
                        m_idx   = m_pops;
                        m_pops++;
                        m_valid = 1'b1;
                    end else if (m_hs) begin
                        m_valid = 1'b0;
                    end
                    if (m_acc == m_total) m_phase = 2;
                end
                default: m_phase = 0;
            endcase
        end
        if (exp_rd) rd_idx++;
    end

    initial begin
        forever begin
            @(posedge clock);
            #2;
            in_data = pix[rd_idx & MASK];
        end
    end

    // One frame: empty_mode 0 never/1 alternate/2 random; ready_mode 0 always/1 low cycles 4..7/2 random
    task automatic applyStimulus(input int r, input int c, input int empty_mode, input int ready_mode,
                                 input bit seq_pix, input bit hold_start);
        int n;
        int target;
        if (seq_pix) for (int k = 0; k < r * c && k <= MASK; k++) pix[(rd_idx + k) & MASK] = DATA_W'(k);
        clearLogs();
        target   = hold_start ? 2 : 1;
        rows     = DIM_W'(r);
        cols     = DIM_W'(c);
        ap_start = 1'b1;
        n = 0;
        while (done_cnt < target && n < TIMEOUT) begin
            case (empty_mode)
                0:       in_empty = 1'b0;
                1:       in_empty = n[0];
                default: in_empty = ($urandom_range(0, 9) < 3);
            endcase
            case (ready_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = !(n >= 4 && n <= 7);
                default: m_axis_tready = ($urandom_range(0, 3) != 0);
            endcase
            @(posedge clock);
            #1;
            n++;
            if (!hold_start || start_cnt >= 2) ap_start = 1'b0;
        end
        checkOutput("frame_done_count", done_cnt, target);
        ap_start      = 1'b0;
        in_empty      = 1'b0;
        m_axis_tready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
    endtask

    initial begin
        int n;
        for (int i = 0; i <= MASK; i++) pix[i] = DATA_W'($urandom);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checkOutput("reset_tvalid", m_axis_tvalid, 0);
        checkOutput("reset_tuser", m_axis_tuser, 0);
        checkOutput("reset_tlast", m_axis_tlast, 0);
        checkOutput("reset_tdata", m_axis_tdata, 0);
        checkOutput("reset_idle", ap_idle, 1);
        checkOutput("reset_done", ap_done, 0);
        @(posedge clock);
        #1;

        $display("[TB] 3x4 frame, FIFO full, tready high");
        applyStimulus(3, 4, 0, 0, 1, 0);
        checkOutput("full_beats", hs_cnt, 12);
        checkOutput("full_first_beat_cyc", first_cyc - start_cyc, 2);
        checkOutput("full_last_beat_cyc", last_cyc - start_cyc, 13);
        checkOutput("full_done_cyc", done_cyc - last_cyc, 1);
        checkOutput("full_tuser_count", tuser_cnt, 1);
        checkOutput("full_tlast_count", tlast_cnt, 3);
        checkOutput("full_pops", rd_cnt, 12);

        $display("[TB] 3x4 frame, four stall cycles");
        applyStimulus(3, 4, 0, 1, 1, 0);
        checkOutput("stall_beats", hs_cnt, 12);
        checkOutput("stall_last_beat_cyc", last_cyc - start_cyc, 17);
        checkOutput("stall_done_cyc", done_cyc - start_cyc, 18);
        checkOutput("stall_beat11", beat_log[11], 11);
`ifdef MAT2AXIS_STALL_MON_EN
        checkOutput("stall_cnt", stall_cnt, 4);
`endif

        $display("[TB] 3x4 frame, FIFO empty every other cycle");
        applyStimulus(3, 4, 1, 0, 1, 0);
        checkOutput("gap_beats", hs_cnt, 12);
        for (int k = 0; k < 12; k++) checkOutput("gap_order", beat_log[k], k);

        $display("[TB] 0x800 frame");
        applyStimulus(0, 800, 0, 0, 0, 0);
        checkOutput("empty_frame_beats", hs_cnt, 0);
        checkOutput("empty_frame_pops", rd_cnt, 0);
        checkOutput("empty_frame_done_cyc", done_cyc - start_cyc, 2);

        $display("[TB] 600x800 frame aborted by reset");
        clearLogs();
        rows = DIM_W'(600);
        cols = DIM_W'(800);
        in_empty = 1'b0;
        m_axis_tready = 1'b1;
        ap_start = 1'b1;
        @(posedge clock);
        #1;
        ap_start = 1'b0;
        n = 0;
        while (hs_cnt < 6 && n < TIMEOUT) begin
            @(posedge clock);
            #1;
            n++;
        end
        checkOutput("beats_before_reset", hs_cnt, 6);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checkOutput("abort_tvalid", m_axis_tvalid, 0);
        checkOutput("abort_idle", ap_idle, 1);
        @(posedge clock);
        #1;
        applyStimulus(2, 2, 0, 0, 1, 0);
        checkOutput("after_reset_beats", hs_cnt, 4);
        checkOutput("after_reset_tuser", tuser_cnt, 1);
        checkOutput("after_reset_beat0", beat_log[0], 0);
        checkOutput("after_reset_tlast", tlast_cnt, 2);

        $display("[TB] ap_start held across DONE");
        applyStimulus(2, 3, 0, 0, 0, 1);
        checkOutput("held_start_frames", start_cnt, 2);
        checkOutput("held_start_gap", start_cyc - first_done_cyc, 1);
        checkOutput("held_start_beats", hs_cnt, 12);

        $display("[TB] randomized frames");
        for (int f = 0; f < 30; f++) begin
            applyStimulus($urandom_range(0, 5), $urandom_range(0, 6), 2, 2, 0, 0);
            checkOutput("rand_beats", hs_cnt, int'(rows) * int'(cols));
            checkOutput("rand_pops", rd_cnt, int'(rows) * int'(cols));
        end

        repeat (3) @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
